// File: rtl/rob_retire_tracker.sv
// Reorder-buffer status tracker: circular head/tail pointers, per-entry valid/finish bits,
// occupancy, N-wide allocate, multi-port writeback, N-wide in-order retire and flush.
module rob_retire_tracker #(
    parameter int NUM_ROB_ENTRY = 32,
    parameter int ROB_WIDTH     = 5,
    parameter int ALLOC_WIDTH   = 2,
    parameter int RETIRE_WIDTH  = 2,
    parameter int NUM_WB        = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ALLOC_WIDTH-1:0]           alloc_valid,
    output logic                             alloc_ready,
    output logic [ALLOC_WIDTH*ROB_WIDTH-1:0] alloc_id,
    input  logic [NUM_WB-1:0]                wb_valid,
    input  logic [NUM_WB*ROB_WIDTH-1:0]      wb_id,
    input  logic                             retire_ack,
    input  logic                             flush,
    output logic [ROB_WIDTH-1:0]             retire_num,
    output logic [ROB_WIDTH-1:0]             head_ptr,
    output logic [ROB_WIDTH-1:0]             tail_ptr,
    output logic [NUM_ROB_ENTRY-1:0]         rob_head,
    output logic [NUM_ROB_ENTRY-1:0]         rob_finish,
    output logic [ROB_WIDTH:0]               rob_count,
    output logic                             rob_full,
    output logic                             rob_empty
);
    localparam int CW = ROB_WIDTH + 1;
    localparam logic [CW-1:0] ENTRIES_C = CW'(NUM_ROB_ENTRY);
    localparam logic [CW-1:0] ALLOC_W_C = CW'(ALLOC_WIDTH);

    logic [ROB_WIDTH-1:0]     head_reg;
    logic [ROB_WIDTH-1:0]     tail_reg;
    logic [CW-1:0]            count_reg;
    logic [NUM_ROB_ENTRY-1:0] valid_reg;
    logic [NUM_ROB_ENTRY-1:0] finish_reg;
    logic [NUM_ROB_ENTRY-1:0] valid_next;
    logic [NUM_ROB_ENTRY-1:0] finish_next;

    logic [CW-1:0]            n_alloc;
    logic [CW-1:0]            n_alloc_eff;
    logic                     alloc_fire;
    logic                     retire_fire;
    logic [RETIRE_WIDTH-1:0]  slot_done;
    logic [ROB_WIDTH-1:0]     retire_num_int;
    logic [ROB_WIDTH-1:0]     n_retire_eff;

    // Readiness depends on registered occupancy only, so there is no path from requests back to ready.
    assign alloc_ready = (ENTRIES_C - count_reg) >= ALLOC_W_C;

    always_comb begin
        n_alloc = '0;
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            n_alloc = n_alloc + CW'(alloc_valid[k]);
        end
    end

    assign alloc_fire  = alloc_ready && (|alloc_valid) && !flush;
    assign n_alloc_eff = alloc_fire ? n_alloc : '0;

    generate
        for (genvar gi = 0; gi < ALLOC_WIDTH; gi++) begin : g_alloc_id
            assign alloc_id[gi*ROB_WIDTH +: ROB_WIDTH] = tail_reg + ROB_WIDTH'(gi);
        end

        for (genvar gi = 0; gi < RETIRE_WIDTH; gi++) begin : g_retire_slot
            logic [ROB_WIDTH-1:0] idx;
            assign idx           = head_reg + ROB_WIDTH'(gi);
            assign slot_done[gi] = valid_reg[idx] && finish_reg[idx];
        end
    endgenerate

    // Length of the finished run starting at head; the first gap ends it.
    always_comb begin
        logic run;
        run            = 1'b1;
        retire_num_int = '0;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            run            = run && slot_done[k];
            retire_num_int = retire_num_int + ROB_WIDTH'(run);
        end
    end

    assign retire_fire  = retire_ack && !flush;
    assign n_retire_eff = retire_fire ? retire_num_int : '0;

    generate
        for (genvar gi = 0; gi < NUM_ROB_ENTRY; gi++) begin : g_entry
            logic [ROB_WIDTH-1:0] alloc_off;
            logic [ROB_WIDTH-1:0] retire_off;
            logic                 alloc_hit;
            logic                 retire_hit;
            logic [NUM_WB-1:0]    wb_match;

            assign alloc_off  = ROB_WIDTH'(gi) - tail_reg;
            assign retire_off = ROB_WIDTH'(gi) - head_reg;
            assign alloc_hit  = alloc_fire && ({1'b0, alloc_off} < n_alloc);
            assign retire_hit = retire_fire && (retire_off < retire_num_int);

            for (genvar gw = 0; gw < NUM_WB; gw++) begin : g_wb
                assign wb_match[gw] = wb_valid[gw] && (wb_id[gw*ROB_WIDTH +: ROB_WIDTH] == ROB_WIDTH'(gi));
            end

            // Retire beats a same-cycle writeback; writebacks only land on live entries.
            assign valid_next[gi]  = !flush && !retire_hit && (alloc_hit || valid_reg[gi]);
            assign finish_next[gi] = !flush && !retire_hit && !alloc_hit &&
                                     (finish_reg[gi] || ((|wb_match) && valid_reg[gi]));
            assign rob_head[gi]    = (head_reg == ROB_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg   <= '0;
            tail_reg   <= '0;
            count_reg  <= '0;
            valid_reg  <= '0;
            finish_reg <= '0;
        end else if (flush) begin
            tail_reg   <= head_reg;
            count_reg  <= '0;
            valid_reg  <= '0;
            finish_reg <= '0;
        end else begin
            head_reg   <= head_reg + n_retire_eff;
            tail_reg   <= tail_reg + ROB_WIDTH'(n_alloc_eff);
            count_reg  <= count_reg + n_alloc_eff - {1'b0, n_retire_eff};
            valid_reg  <= valid_next;
            finish_reg <= finish_next;
        end
    end

    assign retire_num = retire_num_int;
    assign head_ptr   = head_reg;
    assign tail_ptr   = tail_reg;
    assign rob_finish = finish_reg;
    assign rob_count  = count_reg;
    assign rob_full   = (count_reg == ENTRIES_C);
    assign rob_empty  = (count_reg == '0);

endmodule

// File: tb/tb_rob_retire_tracker.sv
// Directed bench for rob_retire_tracker: expected values are queued with the stimulus
// and compared against the DUT once the corresponding edge has been taken.
module tb_rob_retire_tracker;
    localparam int N  = 32;
    localparam int W  = 5;
    localparam int AW = 2;
    localparam int RW = 2;
    localparam int NW = 2;

    localparam int S_COUNT = 0;
    localparam int S_HEAD  = 1;
    localparam int S_TAIL  = 2;
    localparam int S_RNUM  = 3;
    localparam int S_READY = 4;
    localparam int S_FULL  = 5;
    localparam int S_EMPTY = 6;
    localparam int S_RHEAD = 7;
    localparam int S_FIN   = 8;
    localparam int S_AID   = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     alloc_valid;
    logic              alloc_ready;
    logic [AW*W-1:0]   alloc_id;
    logic [NW-1:0]     wb_valid;
    logic [NW*W-1:0]   wb_id;
    logic              retire_ack;
    logic              flush;
    logic [W-1:0]      retire_num;
    logic [W-1:0]      head_ptr;
    logic [W-1:0]      tail_ptr;
    logic [N-1:0]      rob_head;
    logic [N-1:0]      rob_finish;
    logic [W:0]        rob_count;
    logic              rob_full;
    logic              rob_empty;

    always #5 clk = ~clk;

    rob_retire_tracker #(
        .NUM_ROB_ENTRY(N), .ROB_WIDTH(W), .ALLOC_WIDTH(AW), .RETIRE_WIDTH(RW), .NUM_WB(NW)
    ) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
        .wb_valid(wb_valid), .wb_id(wb_id),
        .retire_ack(retire_ack), .flush(flush),
        .retire_num(retire_num), .head_ptr(head_ptr), .tail_ptr(tail_ptr),
        .rob_head(rob_head), .rob_finish(rob_finish), .rob_count(rob_count),
        .rob_full(rob_full), .rob_empty(rob_empty)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;
    int   fails  = 0;

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            S_COUNT: return 64'(rob_count);
            S_HEAD:  return 64'(head_ptr);
            S_TAIL:  return 64'(tail_ptr);
            S_RNUM:  return 64'(retire_num);
            S_READY: return 64'(alloc_ready);
            S_FULL:  return 64'(rob_full);
            S_EMPTY: return 64'(rob_empty);
            S_RHEAD: return 64'(rob_head);
            S_FIN:   return 64'(rob_finish);
            S_AID:   return 64'(alloc_id);
            default: return 64'hdead;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic [63:0] obs;
            e   = exp_q.pop_front();
            obs = observe(e.sel);
            total++;
            assert (obs === e.val) passed++;
            else begin
                fails++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
            $display("check %-12s observed %0h expected %0h", e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic idle_inputs();
        alloc_valid = '0;
        wb_valid    = '0;
        wb_id       = '0;
        retire_ack  = 1'b0;
        flush       = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        expect_val("rst_count", S_COUNT, 64'd0);
        expect_val("rst_head",  S_HEAD,  64'd0);
        expect_val("rst_tail",  S_TAIL,  64'd0);
        expect_val("rst_rhead", S_RHEAD, 64'h1);
        expect_val("rst_empty", S_EMPTY, 64'd1);
        expect_val("rst_full",  S_FULL,  64'd0);
        expect_val("rst_rnum",  S_RNUM,  64'd0);
        expect_val("rst_ready", S_READY, 64'd1);
        tick();
        rst = 1'b0;

        // Three double allocations: ids 0/1, 2/3, 4/5.
        for (int c = 0; c < 3; c++) begin
            alloc_valid = 2'b11;
            expect_val("alloc_id", S_AID, 64'({W'(2*c+1), W'(2*c)}));
            drain();
            tick();
        end
        idle_inputs();
        expect_val("alloc_count", S_COUNT, 64'd6);
        expect_val("alloc_tail",  S_TAIL,  64'd6);
        expect_val("alloc_rnum",  S_RNUM,  64'd0);
        drain();

        // Out-of-order completion: 1 and 2 first, head stays blocked.
        wb_valid = 2'b11; wb_id = {5'd2, 5'd1};
        tick();
        idle_inputs();
        expect_val("ooo_rnum", S_RNUM, 64'd0);
        expect_val("ooo_fin",  S_FIN,  64'h6);
        drain();
        wb_valid = 2'b01; wb_id = {5'd0, 5'd0};
        tick();
        idle_inputs();
        expect_val("head_done_rnum", S_RNUM, 64'd2);
        expect_val("head_done_fin",  S_FIN,  64'h7);
        drain();
        retire_ack = 1'b1;
        tick();
        idle_inputs();
        expect_val("ret_head",  S_HEAD,  64'd2);
        expect_val("ret_rnum",  S_RNUM,  64'd1);
        expect_val("ret_count", S_COUNT, 64'd4);
        expect_val("ret_rhead", S_RHEAD, 64'h4);
        expect_val("ret_fin",   S_FIN,   64'h4);
        drain();

        // Fill to 31 entries.
        for (int c = 0; c < 13; c++) begin
            alloc_valid = 2'b11;
            tick();
        end
        alloc_valid = 2'b01;
        tick();
        idle_inputs();
        expect_val("fill_count", S_COUNT, 64'd31);
        expect_val("fill_ready", S_READY, 64'd0);
        expect_val("fill_tail",  S_TAIL,  64'd1);
        drain();
        alloc_valid = 2'b01;
        tick();
        idle_inputs();
        expect_val("blocked_count", S_COUNT, 64'd31);
        expect_val("blocked_tail",  S_TAIL,  64'd1);
        drain();
        retire_ack = 1'b1;
        tick();
        idle_inputs();
        expect_val("free1_count", S_COUNT, 64'd30);
        expect_val("free1_ready", S_READY, 64'd1);
        expect_val("free1_head",  S_HEAD,  64'd3);
        drain();
        alloc_valid = 2'b11;
        tick();
        idle_inputs();
        expect_val("full_count", S_COUNT, 64'd32);
        expect_val("full_flag",  S_FULL,  64'd1);
        expect_val("full_ready", S_READY, 64'd0);
        expect_val("full_empty", S_EMPTY, 64'd0);
        expect_val("full_tail",  S_TAIL,  64'd3);
        drain();

        // Flush wins over a same-cycle retire and writeback.
        wb_valid = 2'b11; wb_id = {5'd4, 5'd3};
        tick();
        idle_inputs();
        expect_val("pre_flush_rnum", S_RNUM, 64'd2);
        drain();
        flush = 1'b1; retire_ack = 1'b1; wb_valid = 2'b01; wb_id = {5'd0, 5'd5};
        tick();
        idle_inputs();
        expect_val("flush_head",  S_HEAD,  64'd3);
        expect_val("flush_tail",  S_TAIL,  64'd3);
        expect_val("flush_count", S_COUNT, 64'd0);
        expect_val("flush_fin",   S_FIN,   64'd0);
        expect_val("flush_empty", S_EMPTY, 64'd1);
        expect_val("flush_ready", S_READY, 64'd1);
        expect_val("flush_rnum",  S_RNUM,  64'd0);
        drain();
        wb_valid = 2'b01; wb_id = {5'd0, 5'd7};
        tick();
        idle_inputs();
        expect_val("stale_wb_fin", S_FIN, 64'd0);
        drain();

        // Allocate 28 entries (ids 3..30) and complete them all.
        for (int c = 0; c < 14; c++) begin
            alloc_valid = 2'b11;
            tick();
        end
        idle_inputs();
        expect_val("refill_tail",  S_TAIL,  64'd31);
        expect_val("refill_count", S_COUNT, 64'd28);
        drain();
        for (int c = 0; c < 14; c++) begin
            wb_valid = 2'b11; wb_id = {W'(4 + 2*c), W'(3 + 2*c)};
            tick();
        end
        idle_inputs();
        expect_val("allwb_fin",  S_FIN,  64'h7FFF_FFF8);
        expect_val("allwb_rnum", S_RNUM, 64'd2);
        drain();
        for (int c = 0; c < 9; c++) begin
            retire_ack = 1'b1;
            tick();
        end
        idle_inputs();
        expect_val("drain_head",  S_HEAD,  64'd21);
        expect_val("drain_count", S_COUNT, 64'd10);
        drain();

        // Simultaneous allocate 2 and retire 2.
        alloc_valid = 2'b11; retire_ack = 1'b1;
        tick();
        idle_inputs();
        expect_val("simul_count", S_COUNT, 64'd10);
        expect_val("simul_head",  S_HEAD,  64'd23);
        expect_val("simul_tail",  S_TAIL,  64'd1);
        drain();
        for (int c = 0; c < 4; c++) begin
            retire_ack = 1'b1;
            tick();
        end
        idle_inputs();
        expect_val("h31_head",  S_HEAD,  64'd31);
        expect_val("h31_count", S_COUNT, 64'd2);
        expect_val("h31_rnum",  S_RNUM,  64'd0);
        drain();
        retire_ack = 1'b1;
        tick();
        idle_inputs();
        expect_val("noop_ack_head",  S_HEAD,  64'd31);
        expect_val("noop_ack_count", S_COUNT, 64'd2);
        drain();

        // Wrap-around: entries 31 and 0 retire together.
        wb_valid = 2'b11; wb_id = {5'd0, 5'd31};
        tick();
        idle_inputs();
        expect_val("wrap_rnum", S_RNUM, 64'd2);
        expect_val("wrap_fin",  S_FIN,  64'h8000_0001);
        drain();
        retire_ack = 1'b1;
        tick();
        idle_inputs();
        expect_val("wrap_head",  S_HEAD,  64'd1);
        expect_val("wrap_rhead", S_RHEAD, 64'h2);
        expect_val("wrap_count", S_COUNT, 64'd0);
        expect_val("wrap_empty", S_EMPTY, 64'd1);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
